// File: rtl/audio_i2s_clock_tx.sv
// I2S transmitter: waits for a stable PLL lock, then generates BCLK/LRCLK from clk
// and serialises one stereo sample pair per frame through a single-entry holding register.
//   state     | meaning
//   WAIT_LOCK | clocks off, waiting for synchronised lock
//   SETTLE    | lock seen, counting LOCK_WAIT cycles of continuous lock
//   RUN       | clocks and data active
module audio_i2s_clock_tx #(
  parameter int DATA_WIDTH  = 24,
  parameter int BITS_PER_CH = 32,
  parameter int BCLK_DIV    = 4,
  parameter int LOCK_WAIT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic [DATA_WIDTH-1:0] sample_left,
  input  logic [DATA_WIDTH-1:0] sample_right,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  aud_bclk,
  output logic                  aud_daclrck,
  output logic                  aud_dacdat,
  output logic                  running,
  output logic                  underrun
);

  localparam int FRAME_BITS = 2 * BITS_PER_CH;
  localparam int DIV_W      = $clog2(BCLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int SET_W      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t                state, state_nxt;
  logic [1:0]            sync;
  logic                  lk;
  logic [SET_W-1:0]      settle_cnt, settle_nxt;
  logic [DIV_W-1:0]      div_cnt, div_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt, slot;
  logic                  run_nxt, enter, fall, frame_start, accept, right, in_data;
  logic                  held;
  logic [DATA_WIDTH-1:0] hold_l, hold_r, sr_l, sr_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], pll_locked};
  end

  assign lk = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      WAIT_LOCK: begin
        if (lk) begin
          state_nxt  = SETTLE;
          settle_nxt = '0;
        end
      end
      SETTLE: begin
        if (!lk)                                        state_nxt  = WAIT_LOCK;
        else if (settle_cnt == SET_W'(LOCK_WAIT - 1))   state_nxt  = RUN;
        else                                            settle_nxt = settle_cnt + 1'b1;
      end
      RUN:     if (!lk) state_nxt = WAIT_LOCK;
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // Counters are computed one step ahead so every output register lines up with div_cnt.
  always_comb begin
    run_nxt = (state_nxt == RUN);
    enter   = run_nxt && (state != RUN);
    div_nxt = '0;
    bit_nxt = '0;
    if (enter) begin
      bit_nxt = BIT_W'(FRAME_BITS - 1);
    end else if (run_nxt) begin
      div_nxt = (div_cnt == DIV_W'(BCLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
      bit_nxt = bit_cnt;
      if (div_nxt == '0)
        bit_nxt = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
    end
    fall        = run_nxt && (div_nxt == '0);
    frame_start = fall && !enter && (bit_nxt == '0);
    right       = (bit_nxt >= BIT_W'(BITS_PER_CH));
    slot        = right ? bit_nxt - BIT_W'(BITS_PER_CH) : bit_nxt;
    in_data     = (slot >= BIT_W'(1)) && (slot <= BIT_W'(DATA_WIDTH));
    accept      = sample_valid && sample_ready;
  end

  assign sample_ready = running && !held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      running     <= 1'b0;
      aud_bclk    <= 1'b0;
      aud_daclrck <= 1'b0;
      aud_dacdat  <= 1'b0;
      underrun    <= 1'b0;
      held        <= 1'b0;
      hold_l      <= '0;
      hold_r      <= '0;
      sr_l        <= '0;
      sr_r        <= '0;
    end else begin
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      running  <= run_nxt;
      aud_bclk <= run_nxt && (div_nxt >= DIV_W'(BCLK_DIV / 2));
      underrun <= frame_start && !held;
      if (!run_nxt) begin
        aud_daclrck <= 1'b0;
        aud_dacdat  <= 1'b0;
        held        <= 1'b0;
        hold_l      <= '0;
        hold_r      <= '0;
        sr_l        <= '0;
        sr_r        <= '0;
      end else begin
        if (frame_start) begin
          sr_l <= held ? hold_l : '0;
          sr_r <= held ? hold_r : '0;
          held <= 1'b0;
        end
        // An accept in the frame-start cycle wins over the clear: it plays next frame.
        if (accept) begin
          hold_l <= sample_left;
          hold_r <= sample_right;
          held   <= 1'b1;
        end
        if (fall) begin
          aud_daclrck <= right;
          aud_dacdat  <= 1'b0;
          if (in_data) begin
            if (right) begin
              aud_dacdat <= sr_r[DATA_WIDTH-1];
              sr_r       <= sr_r << 1;
            end else begin
              aud_dacdat <= sr_l[DATA_WIDTH-1];
              sr_l       <= sr_l << 1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_clock_tx.sv
// Scoreboard bench for audio_i2s_clock_tx: a frame-level model predicts each frame's
// contents and the per-cycle handshake/underrun/lock behaviour from plain timing arithmetic.
module tb_audio_i2s_clock_tx;
  localparam int DW    = 24;
  localparam int B     = 32;
  localparam int DIV   = 4;
  localparam int LW    = 1024;
  localparam int FRAME = 2 * B * DIV;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic clk = 1'b0, rst = 1'b1, pll_locked = 1'b0;
  logic [DW-1:0] sample_left = '0, sample_right = '0;
  logic sample_valid = 1'b0;
  logic sample_ready, aud_bclk, aud_daclrck, aud_dacdat, running, underrun;

  audio_i2s_clock_tx #(.DATA_WIDTH(DW), .BITS_PER_CH(B), .BCLK_DIV(DIV), .LOCK_WAIT(LW)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .sample_left(sample_left), .sample_right(sample_right), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(aud_dacdat), .running(running), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_frames = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [2*B-1:0] exp_bits(input pair_t p);
    logic [2*B-1:0] v;
    logic [DW-1:0]  ch;
    int s;
    v = '0;
    for (int i = 0; i < 2*B; i++) begin
      s  = i % B;
      ch = (i < B) ? p.l : p.r;
      if (s >= 1 && s <= DW) v[i] = ch[DW-s];
    end
    return v;
  endfunction

  // Reference model: running after LW+3 consecutive locked edges, drops on the 3rd unlocked
  // edge; frames start 4 edges after entering RUN and every FRAME edges thereafter.
  pair_t exp_q[$];
  pair_t m_hold;
  int    hi_cnt, lo_cnt, e;
  bit    m_run, m_held, exp_under, pre, acc, fs, nrun;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt = 0; lo_cnt = 0; e = 0;
      m_run = 0; m_held = 0; exp_under = 0;
      exp_q.delete();
    end else begin
      pre = m_run;
      acc = pre && sample_valid && !m_held;
      if (pll_locked) begin hi_cnt++; lo_cnt = 0; end
      else            begin lo_cnt++; hi_cnt = 0; end
      nrun = pre ? (lo_cnt < 3) : (hi_cnt >= LW + 3);
      exp_under = 0;
      if (!nrun) begin
        m_held = 0;
        if (pre) exp_q.delete();
      end else if (!pre) begin
        e = 0;
        m_held = 0;
      end else begin
        e++;
        fs = (e >= 4) && (((e - 4) % FRAME) == 0);
        if (fs) begin
          exp_q.push_back(m_held ? m_hold : pair_t'('0));
          exp_under = !m_held;
          m_held = 0;
        end
        if (acc) begin
          m_hold = {sample_left, sample_right};
          m_held = 1;
        end
      end
      m_run = nrun;
    end
  end

  // Monitor: per-cycle control checks, and frame assembly on BCLK rising edges.
  int idx = -1;
  bit prev_bclk = 0, prev_lr = 0;
  logic [2*B-1:0] got_d, got_lr;
  pair_t exp_p;

  always @(negedge clk) begin
    if (!rst) begin
      chk("running", running, m_run);
      chk("ready", sample_ready, m_run && !m_held);
      chk("underrun", underrun, exp_under);
      if (!m_run) begin
        chk("idle_outs", {aud_bclk, aud_daclrck, aud_dacdat}, 0);
        idx = -1; prev_bclk = 0; prev_lr = 0;
      end else begin
        chk("bclk", aud_bclk, (e % DIV) >= DIV/2);
        if (aud_bclk && !prev_bclk) begin
          if (!aud_daclrck && prev_lr) idx = 0;
          if (idx >= 0) begin
            got_d[idx]  = aud_dacdat;
            got_lr[idx] = aud_daclrck;
            idx++;
            if (idx == 2*B) begin
              idx = -1;
              n_frames++;
              chk("frame_pending", exp_q.size(), 1);
              if (exp_q.size() > 0) begin
                exp_p = exp_q.pop_front();
                chk("frame_data", got_d, exp_bits(exp_p));
                chk("frame_lrck", got_lr, {{B{1'b1}}, {B{1'b0}}});
              end
            end
          end
          prev_lr = aud_daclrck;
        end
        prev_bclk = aud_bclk;
      end
    end
  end

  function automatic logic sel(input bit is_lr);
    return is_lr ? aud_daclrck : aud_bclk;
  endfunction

  task automatic measure(input bit is_lr, output int hi, output int lo);
    int n;
    hi = 0; lo = 0; n = 0;
    while (sel(is_lr) !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    while (sel(is_lr) !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    while (sel(is_lr) === 1'b1 && hi < 1000) begin @(negedge clk); hi++; end
    while (sel(is_lr) === 1'b0 && lo < 1000) begin @(negedge clk); lo++; end
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int n;
    n = 0;
    sample_left = l; sample_right = r; sample_valid = 1'b1;
    while (!sample_ready && n < 2000) begin @(negedge clk); n++; end
    chk("send_in_time", n < 2000, 1);
    @(negedge clk);
  endtask

  task automatic wait_locked(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!running && n < LW + 50);
    chk(name, n, LW + 3);
  endtask

  int hi, lo, n;

  initial begin
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs", {running, sample_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun}, 0);
    rst = 1'b0;
    wait_locked("lock_latency");

    measure(0, hi, lo);
    chk("bclk_high", hi, DIV/2);
    chk("bclk_low", lo, DIV/2);
    measure(1, hi, lo);
    chk("lrck_high", hi, FRAME/2);
    chk("lrck_low", lo, FRAME/2);

    send(24'hABCDEF, 24'h123456);
    sample_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(DW'($urandom), DW'($urandom));
      sample_valid = 1'b0;
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end

    send(DW'($urandom), DW'($urandom));
    send(DW'($urandom), DW'($urandom));
    send(DW'($urandom), DW'($urandom));
    sample_valid = 1'b0;
    repeat (3 * FRAME) @(negedge clk);

    n = 0;
    while (aud_daclrck !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    while (aud_daclrck !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    send(DW'($urandom), DW'($urandom));
    sample_valid = 1'b0;
    repeat (10) @(negedge clk);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    chk("lockloss_outs", {running, sample_ready, aud_bclk, aud_daclrck, aud_dacdat}, 0);
    repeat (20) @(negedge clk);
    pll_locked = 1'b1;
    wait_locked("relock_latency");
    repeat (2 * FRAME) @(negedge clk);
    send(DW'($urandom), DW'($urandom));
    sample_valid = 1'b0;
    repeat (2 * FRAME + 20) @(negedge clk);

    chk("frames_seen", n_frames >= 14, 1);

    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_outs", {running, sample_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun}, 0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
